// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with bypass, zero flag,
// one-deep shadow bank and sequenced clear engine.
module regfile_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              zflag,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];
  logic              shadow_z;
  logic              wr_accept;

  // Restore wins over the write, and nothing is written while clearing.
  assign wr_accept = we && !restore_req && (state == IDLE) && !rst;

  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (BYPASS && wr_accept && (waddr == raddr_a)) rdata_a = wdata;
    if (BYPASS && wr_accept && (waddr == raddr_b)) rdata_b = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
      shadow_z <= 1'b0;
      zflag    <= 1'b0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      clr_cnt  <= '0;
      state    <= IDLE;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (restore_req) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= shadow[i];
            zflag <= shadow_z;
          end else begin
            // Save snapshots pre-edge values, so a same-cycle write is not captured.
            if (save_req) begin
              for (int i = 0; i < DEPTH; i++) shadow[i] <= regs[i];
              shadow_z <= zflag;
            end
            if (we) begin
              regs[waddr] <= wdata;
              zflag       <= (wdata == '0);
            end
          end
          if (clr_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          regs[clr_cnt] <= '0;
          if (clr_cnt == LAST_IDX) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
            clr_cnt  <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param: stimulus pushes
// expectations, a negedge monitor pops and compares them.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, save_req, restore_req, clr_req;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata, rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
  logic        zflag, busy, clr_done, nb_zflag, nb_busy, nb_clr_done;

  logic        s_we, s_save_req, s_restore_req, s_clr_req;
  logic [1:0]  s_waddr, s_raddr_a, s_raddr_b;
  logic [7:0]  s_wdata, s_rdata_a, s_rdata_b;
  logic        s_zflag, s_busy, s_clr_done;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .zflag(zflag), .save_req(save_req), .restore_req(restore_req),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(nb_rdata_a), .raddr_b(raddr_b), .rdata_b(nb_rdata_b),
    .zflag(nb_zflag), .save_req(save_req), .restore_req(restore_req),
    .clr_req(clr_req), .busy(nb_busy), .clr_done(nb_clr_done)
  );

  regfile_param #(.DATA_W(8), .ADDR_W(2), .BYPASS(1'b1)) dut_s (
    .clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .raddr_a(s_raddr_a), .rdata_a(s_rdata_a), .raddr_b(s_raddr_b), .rdata_b(s_rdata_b),
    .zflag(s_zflag), .save_req(s_save_req), .restore_req(s_restore_req),
    .clr_req(s_clr_req), .busy(s_busy), .clr_done(s_clr_done)
  );

  typedef enum int {K_A, K_B, K_Z, K_BUSY, K_DONE, K_NB_A, K_S_A, K_S_BUSY, K_S_DONE} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic [31:0] actual(kind_t k);
    case (k)
      K_A:      return {16'h0, rdata_a};
      K_B:      return {16'h0, rdata_b};
      K_Z:      return {31'h0, zflag};
      K_BUSY:   return {31'h0, busy};
      K_DONE:   return {31'h0, clr_done};
      K_NB_A:   return {16'h0, nb_rdata_a};
      K_S_A:    return {24'h0, s_rdata_a};
      K_S_BUSY: return {31'h0, s_busy};
      K_S_DONE: return {31'h0, s_clr_done};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(kind_t k, logic [31:0] v, string name);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = actual(e.kind);
      compared++;
      if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(logic [2:0] a, logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 0; save_req = 0; restore_req = 0; clr_req = 0;
    waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
    s_we = 0; s_save_req = 0; s_restore_req = 0; s_clr_req = 0;
    s_waddr = 0; s_wdata = 0; s_raddr_a = 0; s_raddr_b = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    raddr_a = 3'd3; raddr_b = 3'd7;
    expect_val(K_A, 32'h0, "reset_rdata_a");
    expect_val(K_B, 32'h0, "reset_rdata_b");
    expect_val(K_Z, 32'h0, "reset_zflag");
    expect_val(K_BUSY, 32'h0, "reset_busy");
    expect_val(K_DONE, 32'h0, "reset_clr_done");
    step();

    // Write / read / zflag
    write(3'd3, 16'h1234);
    write(3'd5, 16'h0000);
    raddr_a = 3'd3; raddr_b = 3'd5;
    expect_val(K_A, 32'h1234, "rd_reg3");
    expect_val(K_B, 32'h0000, "rd_reg5");
    expect_val(K_Z, 32'h1, "zflag_after_zero_write");
    step();
    write(3'd3, 16'h00FF);
    expect_val(K_Z, 32'h0, "zflag_after_nonzero_write");
    expect_val(K_A, 32'h00FF, "rd_reg3_rewritten");
    step();

    // Bypass: same-cycle forwarding only on the BYPASS=1 instance
    we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF; raddr_a = 3'd2; raddr_b = 3'd2;
    expect_val(K_A, 32'hBEEF, "bypass_port_a");
    expect_val(K_B, 32'hBEEF, "bypass_port_b");
    expect_val(K_NB_A, 32'h0000, "no_bypass_old_value");
    step();
    we = 1'b0;
    expect_val(K_NB_A, 32'hBEEF, "no_bypass_after_edge");
    step();

    // Save / restore
    for (int i = 0; i < 8; i++) write(3'(i), 16'h1000 + 16'(i));
    save_req = 1'b1;
    write(3'd0, 16'h0000);
    save_req = 1'b0;
    raddr_a = 3'd0;
    expect_val(K_A, 32'h0000, "save_write_performed");
    expect_val(K_Z, 32'h1, "save_write_zflag");
    step();
    for (int i = 0; i < 8; i++) write(3'(i), 16'hA0A0 + 16'(i));
    restore_req = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 16'h5555; raddr_a = 3'd1;
    expect_val(K_A, 32'hA0A1, "restore_cycle_no_bypass");
    step();
    restore_req = 1'b0; we = 1'b0;
    expect_val(K_Z, 32'h0, "restore_zflag");
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      expect_val(K_A, 32'h1000 + i, $sformatf("restore_reg%0d", i));
      step();
    end

    // Clear sequence with ignored writes and clr_req held through the last cycle
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    we = 1'b1; waddr = 3'd7; wdata = 16'h0000;
    for (int j = 0; j < 8; j++) begin
      raddr_a = 3'(j);
      expect_val(K_A, 32'h1000 + j, $sformatf("clear_pre_reg%0d", j));
      if (j > 0) begin
        raddr_b = 3'(j - 1);
        expect_val(K_B, 32'h0, $sformatf("clear_post_reg%0d", j - 1));
      end
      expect_val(K_BUSY, 32'h1, $sformatf("clear_busy_%0d", j));
      expect_val(K_DONE, 32'h0, $sformatf("clear_no_done_%0d", j));
      expect_val(K_Z, 32'h0, $sformatf("clear_zflag_%0d", j));
      if (j == 7) clr_req = 1'b1;
      step();
    end
    we = 1'b0; clr_req = 1'b0;
    raddr_b = 3'd7;
    expect_val(K_B, 32'h0, "clear_post_reg7");
    expect_val(K_BUSY, 32'h0, "clear_busy_end");
    expect_val(K_DONE, 32'h1, "clear_done_pulse");
    step();
    expect_val(K_DONE, 32'h0, "clear_done_one_cycle");
    expect_val(K_BUSY, 32'h0, "clear_no_restart");
    step();

    // Reset mid-clear
    write(3'd2, 16'h7777);
    write(3'd6, 16'h8888);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    raddr_a = 3'd6; raddr_b = 3'd2;
    expect_val(K_A, 32'h0, "midclr_reset_reg6");
    expect_val(K_B, 32'h0, "midclr_reset_reg2");
    expect_val(K_BUSY, 32'h0, "midclr_reset_busy");
    for (int j = 0; j < 8; j++) begin
      expect_val(K_DONE, 32'h0, $sformatf("midclr_no_done_%0d", j));
      step();
    end

    // Parameter sweep: DATA_W=8, ADDR_W=2
    s_we = 1'b1; s_waddr = 2'd3; s_wdata = 8'hFF;
    step();
    s_we = 1'b0; s_raddr_a = 2'd3;
    expect_val(K_S_A, 32'hFF, "sweep_rd_reg3");
    step();
    s_clr_req = 1'b1;
    step();
    s_clr_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      expect_val(K_S_BUSY, 32'h1, $sformatf("sweep_busy_%0d", j));
      expect_val(K_S_DONE, 32'h0, $sformatf("sweep_no_done_%0d", j));
      step();
    end
    expect_val(K_S_BUSY, 32'h0, "sweep_busy_end");
    expect_val(K_S_DONE, 32'h1, "sweep_done_pulse");
    expect_val(K_S_A, 32'h0, "sweep_reg3_cleared");
    step();
    expect_val(K_S_DONE, 32'h0, "sweep_done_one_cycle");
    step();

    step(); step();
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file that succeeds the fixed PC/IR/ACC/MDR/MAR register bank. It provides DEPTH registers of DATA_W bits, with one write port, two asynchronous read ports with write-to-read bypass, and a registered zero flag. It also carries a one-cycle shadow bank for context save/restore and a sequenced clear engine. It sits between the control unit and the datapath.

## Interface
- DATA_W, 16, register width in bits (≥1)
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = read ports forward same-cycle accepted write data; 0 = no forwarding
- clk  in  1  sole clock, all state changes on posedge
- rst  in  1  synchronous, active-high reset, sampled on posedge clk
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr_a  in  ADDR_W  read address, port A
- rdata_a  out  DATA_W  read data, port A (combinational)
- raddr_b  in  ADDR_W  read address, port B
- rdata_b  out  DATA_W  read data, port B (combinational)
- zflag  out  1  registered: 1 when the last accepted write had wdata == 0
- save_req  in  1  copy all registers and zflag into the shadow bank
- restore_req  in  1  copy the shadow bank back into the registers and zflag
- clr_req  in  1  start a sequential clear of all registers
- busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse when the clear sequence completes

## Operation
- Reset (rst=1 at posedge) drives the following to 0: all registers, shadow registers, shadow zflag, zflag, busy, clr_done, and the clear counter.
  - Reset overrides every other input.
  - Reset during a clear aborts it; no clr_done is issued.
- State machine: IDLE, CLEAR.
  - IDLE→CLEAR when clr_req=1 at a posedge.
  - CLEAR→IDLE after the register at index DEPTH-1 is cleared.
- IDLE priority at a posedge: restore_req > save_req > write.
  - restore: regs ← shadow, zflag ← shadow zflag. A write in the same cycle is dropped.
  - save: shadow ← pre-edge register values and pre-edge zflag. A write in the same cycle is still performed into the main registers.
  - A write is accepted when we=1, no restore, and state IDLE. On acceptance: reg[waddr] ← wdata and zflag ← (wdata == 0).
  - clr_req in IDLE is accepted alongside the above. That cycle's write, save and restore still take effect.
- CLEAR behaviour:
  - One register is zeroed per cycle, index 0 upward, driven by an ADDR_W-bit counter.
  - we, save_req, restore_req and clr_req are ignored.
  - zflag and the shadow bank are unchanged.
- Read ports:
  - rdata = reg[raddr].
  - If BYPASS=1 and a write is accepted this cycle with waddr == raddr, rdata = wdata.
  - Ports A and B are independent and may use the same address.
  - No bypass applies to restore data or to clear zeroing.

## Timing
- Write latency: 1 cycle to the register. With BYPASS=1 the value is visible on a read port in the same cycle.
- zflag updates at the posedge that accepts the write.
- save and restore each complete in 1 cycle.
- Clear, with clr_req sampled in IDLE at edge k:
  - busy is high after edge k.
  - Edges k+1 .. k+DEPTH zero registers 0 .. DEPTH-1.
  - After edge k+DEPTH: busy=0 and clr_done=1 for exactly one cycle.
  - Total busy time is DEPTH cycles.
- clr_req held high through the final clear cycle starts a new sequence only if it is still high at the posedge when busy is already 0. No back-to-back restart occurs from the clr_done edge.
- Counter wrap: the counter returns to 0 on the transition to IDLE.

## Test plan
- Reset/write/read: after reset, both ports read 0 and zflag=0. Write reg3=0x1234, then reg5=0x0000. Required: raddr_a=3 gives 0x1234, raddr_b=5 gives 0x0000, zflag=1. Then write reg3=0x00FF → zflag=0.
- Bypass: BYPASS=1, we=1, waddr=2, wdata=0xBEEF, raddr_a=2 in the same cycle → rdata_a=0xBEEF before the edge. With BYPASS=0, rdata_a shows the old value (0) in the same cycle.
- Save/restore: load regs 0..7 with 0x1000+i and set zflag=0. Assert save_req together with a write of reg0=0 → reg0 becomes 0, shadow reg0 holds 0x1000. Overwrite all registers, then assert restore_req with we=1 to reg1 → all regs return to 0x1000+i, the write is dropped, zflag=0.
- Clear sequence: DEPTH=8, all regs nonzero; pulse clr_req. Required:
  - busy is high for 8 cycles.
  - reg i reads 0 after edge k+1+i.
  - we pulses during busy are ignored.
  - clr_done is high exactly one cycle after edge k+8.
- Reset mid-clear: assert rst at edge k+4 → all regs 0, busy=0, and no clr_done pulse follows.
- Parameter sweep: DATA_W=8, ADDR_W=2. A write of 0xFF to reg3 reads back 0xFF, and the clear takes exactly 4 busy cycles.
